// File: rtl/aes_pkg.sv
// Shared AES package: FSM encodings, round count and the GF(2^8) helpers
// used by the inverse cipher datapath.
package aes_pkg;

    localparam int AES_128_ROUNDS = 10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT,
        ST_SHIFT,
        ST_SBOX,
        ST_MAIN
    } dec_state_t;

    // Multiply by x modulo x^8+x^4+x^3+x+1 (0x11b)
    function automatic logic [7:0] mul2(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] mul9(input logic [7:0] a);
        return mul2(mul2(mul2(a))) ^ a;
    endfunction

    function automatic logic [7:0] mul11(input logic [7:0] a);
        return mul2(mul2(mul2(a))) ^ mul2(a) ^ a;
    endfunction

    function automatic logic [7:0] mul13(input logic [7:0] a);
        return mul2(mul2(mul2(a))) ^ mul2(mul2(a)) ^ a;
    endfunction

    function automatic logic [7:0] mul14(input logic [7:0] a);
        return mul2(mul2(mul2(a))) ^ mul2(mul2(a)) ^ mul2(a);
    endfunction

    // One column through the {0e,0b,0d,09} circulant; row 0 is the top byte
    function automatic logic [31:0] invMixWord(input logic [31:0] w);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = w;
        return {mul14(a0) ^ mul11(a1) ^ mul13(a2) ^ mul9(a3),
                mul9(a0)  ^ mul14(a1) ^ mul11(a2) ^ mul13(a3),
                mul13(a0) ^ mul9(a1)  ^ mul14(a2) ^ mul11(a3),
                mul11(a0) ^ mul13(a1) ^ mul9(a2)  ^ mul14(a3)};
    endfunction

    // Row r of word j takes the byte from word (j-r) mod 4 (right rotation)
    function automatic logic [127:0] invShiftRows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int j = 0; j < 4; j++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-32*j-8*r -: 8] = s[127-32*((j-r+4)%4)-8*r -: 8];
            end
        end
        return o;
    endfunction

endpackage

// File: rtl/aes_decipher_block_if.sv
// Bus between the decipher core, its controller, the key store and the
// shared inverse S-box.
interface aes_decipher_block_if;
    logic         next;
    logic [3:0]   round;
    logic [127:0] roundKey;
    logic [31:0]  invSBoxRequest;
    logic [31:0]  invSBoxResponse;
    logic [127:0] block;
    logic [127:0] newBlock;
    logic         ready;

    modport master (
        output next, roundKey, invSBoxResponse, block,
        input  round, invSBoxRequest, newBlock, ready
    );

    modport slave (
        input  next, roundKey, invSBoxResponse, block,
        output round, invSBoxRequest, newBlock, ready
    );
endinterface

// File: rtl/aes_inv_mixcolumns.sv
// Combinational InvMixColumns over the full 128-bit state, one column
// (32-bit word, w0 at the top) per invMixWord.
module aes_inv_mixcolumns
    import aes_pkg::*;
(
    input  logic [127:0] din,
    output logic [127:0] dout
);
    for (genvar i = 0; i < 4; i++) begin : g_col
        assign dout[127-32*i -: 32] = invMixWord(din[127-32*i -: 32]);
    end
endmodule

// File: rtl/aes_decipher_block.sv
// Iterative AES decryption core. Round keys and inverse S-box are external
// and combinational. Optional build macro AES_DEC_MERGED_SHIFT_EN folds
// invShiftRows into INIT/MAIN, dropping the SHIFT state (5-cycle rounds).
module aes_decipher_block
    import aes_pkg::*;
#(
    parameter int NUM_ROUNDS = AES_128_ROUNDS
) (
    input  logic                 clk,
    input  logic                 reset,
    aes_decipher_block_if.slave  bus
);
    dec_state_t          state;
    logic [0:3][31:0]    w;
    logic [1:0]          wctr;
    logic [3:0]          rctr;
    logic                ready_q;
    logic [127:0]        key_add;
    logic [127:0]        mix_out;

    assign key_add = w ^ bus.roundKey;

    aes_inv_mixcolumns u_mix (
        .din  (key_add),
        .dout (mix_out)
    );

    assign bus.round    = rctr;
    assign bus.newBlock = w;
    assign bus.ready    = ready_q;

    // Only the SBOX state presents a word to the shared S-box
    always_comb begin
        bus.invSBoxRequest = '0;
        if (state == ST_SBOX) bus.invSBoxRequest = w[wctr];
    end

    // Round sequencer and working state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= ST_IDLE;
            w       <= '0;
            wctr    <= '0;
            rctr    <= '0;
            ready_q <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.next) begin
                        rctr    <= 4'(NUM_ROUNDS);
                        ready_q <= 1'b0;
                        state   <= ST_INIT;
                    end
                end
                ST_INIT: begin
`ifdef AES_DEC_MERGED_SHIFT_EN
                    w     <= invShiftRows(bus.block ^ bus.roundKey);
                    wctr  <= '0;
                    state <= ST_SBOX;
`else
                    w     <= bus.block ^ bus.roundKey;
                    state <= ST_SHIFT;
`endif
                    rctr  <= rctr - 4'd1;
                end
                ST_SHIFT: begin
                    w     <= invShiftRows(w);
                    wctr  <= '0;
                    state <= ST_SBOX;
                end
                ST_SBOX: begin
                    w[wctr] <= bus.invSBoxResponse;
                    wctr    <= wctr + 2'd1;
                    if (wctr == 2'd3) state <= ST_MAIN;
                end
                ST_MAIN: begin
                    if (rctr != 4'd0) begin
`ifdef AES_DEC_MERGED_SHIFT_EN
                        w     <= invShiftRows(mix_out);
                        wctr  <= '0;
                        state <= ST_SBOX;
`else
                        w     <= mix_out;
                        state <= ST_SHIFT;
`endif
                        rctr  <= rctr - 4'd1;
                    end else begin
                        // Final round has no InvMixColumns; rctr stays at 0
                        w       <= key_add;
                        ready_q <= 1'b1;
                        state   <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_aes_decipher_block.sv
// Bench for aes_decipher_block: forward-AES reference model, randomized and
// FIPS-197 vectors, scoreboard queue popped by an independent monitor.
`timescale 1ns/1ps
module tb_aes_decipher_block;
    localparam int NR = 10;
`ifdef AES_DEC_MERGED_SHIFT_EN
    localparam int LAT = 1 + 5*NR;
`else
    localparam int LAT = 1 + 6*NR;
`endif

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    aes_decipher_block_if bus();

    aes_decipher_block #(.NUM_ROUNDS(NR)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [7:0]   sbox [256];
    logic [7:0]   isbox [256];
    logic [127:0] rk [16];

    // Key store and shared inverse S-box, both combinational
    assign bus.roundKey = rk[bus.round];
    assign bus.invSBoxResponse = {isbox[bus.invSBoxRequest[31:24]], isbox[bus.invSBoxRequest[23:16]],
                                  isbox[bus.invSBoxRequest[15:8]],  isbox[bus.invSBoxRequest[7:0]]};

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    logic [127:0] exp_q [$];
    int last_hi = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p ^= a;
            a = xt(a);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rl(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    task automatic build_sbox();
        logic [7:0] inv, x;
        for (int i = 0; i < 256; i++) begin
            x = 8'(i);
            inv = 8'h00;
            for (int y = 1; y < 256; y++) if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
            sbox[i] = inv ^ rl(inv, 1) ^ rl(inv, 2) ^ rl(inv, 3) ^ rl(inv, 4) ^ 8'h63;
        end
        for (int i = 0; i < 256; i++) isbox[sbox[i]] = 8'(i);
    endtask

    function automatic logic [31:0] subw(input logic [31:0] v);
        return {sbox[v[31:24]], sbox[v[23:16]], sbox[v[15:8]], sbox[v[7:0]]};
    endfunction

    task automatic set_key(input logic [127:0] key);
        logic [31:0] wk [44];
        logic [31:0] t;
        logic [7:0]  rcon = 8'h01;
        for (int i = 0; i < 4; i++) wk[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = wk[i-1];
            if (i % 4 == 0) begin
                t = subw({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
                rcon = xt(rcon);
            end
            wk[i] = wk[i-4] ^ t;
        end
        for (int r = 0; r <= NR; r++) rk[r] = {wk[4*r], wk[4*r+1], wk[4*r+2], wk[4*r+3]};
    endtask

    // Forward cipher: the bench feeds its output to the DUT and expects pt back
    function automatic logic [127:0] encrypt(input logic [127:0] pt);
        logic [7:0] b [16];
        logic [7:0] t [16];
        logic [7:0] a0, a1, a2, a3;
        logic [127:0] s;
        s = pt ^ rk[0];
        for (int r = 1; r <= NR; r++) begin
            for (int i = 0; i < 16; i++) b[i] = sbox[s[127-8*i -: 8]];
            for (int c = 0; c < 4; c++)
                for (int q = 0; q < 4; q++) t[4*c+q] = b[4*((c+q)%4)+q];
            if (r < NR) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                    t[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                    t[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                    t[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                    t[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
                end
            end
            for (int i = 0; i < 16; i++) s[127-8*i -: 8] = t[i];
            s ^= rk[r];
        end
        return s;
    endfunction

    // ---------------- monitor / scoreboard ----------------
    initial begin : monitor
        logic prev_rdy = 1'b1;
        int   t_start = 0;
        int   hi_cnt = 0;
        int   rlog [$];
        int   bad;
        logic [127:0] e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                prev_rdy = 1'b1;
                rlog.delete();
            end else begin
                if (prev_rdy && !bus.ready) begin
                    t_start = cyc;
                    last_hi = hi_cnt;
                    hi_cnt  = 0;
                    rlog.delete();
                end
                if (!bus.ready && (rlog.size() == 0 || rlog[$] != int'(bus.round)))
                    rlog.push_back(int'(bus.round));
                if (bus.ready) hi_cnt++;
                if (!prev_rdy && bus.ready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_result", 128'(1), 128'(0));
                    end else begin
                        e = exp_q.pop_front();
                        chk("plaintext", bus.newBlock, e);
                        chk("latency", 128'(cyc - t_start), 128'(LAT));
                        bad = -1;
                        for (int i = 0; i <= NR; i++)
                            if (bad < 0 && (i >= rlog.size() || rlog[i] != NR - i)) bad = i;
                        if (bad < 0 && rlog.size() != NR + 1) bad = NR + 1;
                        chk("round_seq_first_bad_idx", 128'(bad), 128'(-1));
                    end
                end
                prev_rdy = bus.ready;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_ready(input string name);
        int n = 0;
        while (!bus.ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!bus.ready) chk({name, "_timeout"}, 128'(0), 128'(1));
    endtask

    task automatic run(input logic [127:0] ct, input logic [127:0] pt);
        @(negedge clk);
        bus.block = ct;
        bus.next  = 1'b1;
        exp_q.push_back(pt);
        @(negedge clk);
        bus.next  = 1'b0;
        wait_ready("run");
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [127:0] kB, ptB, ctB, kC, ptC, ctC, k, pt, ct, ct2, pt2;
        kB  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        ptB = 128'h3243f6a8885a308d313198a2e0370734;
        ctB = 128'h3925841d02dc09fbdc118597196a0b32;
        kC  = 128'h000102030405060708090a0b0c0d0e0f;
        ptC = 128'h00112233445566778899aabbccddeeff;
        ctC = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        bus.next  = 1'b0;
        bus.block = '0;
        for (int i = 0; i < 16; i++) rk[i] = '0;
        build_sbox();

        // Reset values after release
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("reset_ready", 128'(bus.ready), 128'(1));
        chk("reset_newBlock", bus.newBlock, 128'(0));
        chk("reset_round", 128'(bus.round), 128'(0));
        chk("reset_sbox_req", 128'(bus.invSBoxRequest), 128'(0));

        // FIPS-197 App. B and C.1
        set_key(kB);
        chk("model_appB", encrypt(ptB), ctB);
        run(ctB, ptB);
        set_key(kC);
        chk("model_c1", encrypt(ptC), ctC);
        run(ctC, ptC);

        // next pulsed while busy is ignored
        set_key(kB);
        @(negedge clk);
        bus.block = ctB;
        bus.next  = 1'b1;
        exp_q.push_back(ptB);
        @(negedge clk);
        bus.next  = 1'b0;
        repeat (19) @(negedge clk);
        bus.next  = 1'b1;
        @(negedge clk);
        bus.next  = 1'b0;
        wait_ready("busy_next");

        // Reset mid-operation, then a clean run
        @(negedge clk);
        bus.block = ctC;
        bus.next  = 1'b1;
        @(negedge clk);
        bus.next  = 1'b0;
        repeat (29) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("abort_ready", 128'(bus.ready), 128'(1));
        chk("abort_newBlock", bus.newBlock, 128'(0));
        chk("abort_round", 128'(bus.round), 128'(0));
        reset = 1'b1;
        run(ctB, ptB);

        // Randomized keys and plaintexts
        for (int n = 0; n < 6; n++) begin
            k  = {$urandom, $urandom, $urandom, $urandom};
            pt = {$urandom, $urandom, $urandom, $urandom};
            set_key(k);
            ct = encrypt(pt);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            run(ct, pt);
        end

        // Back-to-back with next held high; block swapped while ready=1
        k   = {$urandom, $urandom, $urandom, $urandom};
        pt  = {$urandom, $urandom, $urandom, $urandom};
        pt2 = {$urandom, $urandom, $urandom, $urandom};
        set_key(k);
        ct  = encrypt(pt);
        ct2 = encrypt(pt2);
        @(negedge clk);
        bus.block = ct;
        bus.next  = 1'b1;
        exp_q.push_back(pt);
        exp_q.push_back(pt2);
        @(negedge clk);
        wait_ready("b2b_first");
        bus.block = ct2;
        @(negedge clk);
        wait_ready("b2b_second");
        bus.next  = 1'b0;
        chk("b2b_ready_high_cycles", 128'(last_hi), 128'(1));

        repeat (5) @(negedge clk);
        chk("scoreboard_drained", 128'(exp_q.size()), 128'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/aes_decipher_block.md
# aes_decipher_block

Iterative AES-128 decryption datapath, the inverse counterpart of the team's encryption round engine. It takes a 128-bit ciphertext block and produces the plaintext in place. Round keys come from the shared key-expansion memory, indexed by the `round` output. Inverse S-box lookups go to an external shared inverse S-box, one 32-bit word per cycle.

## Interface
- `NUM_ROUNDS`, default 10: number of AES rounds. Legal values are 10, 12 and 14; must fit in 4 bits.
- `clk` in 1: clock. Reset is `reset`, asynchronous, active-low; clock is `clk`.
- `reset` in 1: asynchronous, active-low.
- `next` in 1: start request. Sampled only in IDLE.
- `round` out 4: round-key index requested from the key store.
- `roundKey` in 128: round key for `round`. Must be valid combinationally in the same cycle.
- `invSBoxRequest` out 32: word presented to the inverse S-box (4 bytes in parallel).
- `invSBoxResponse` in 32: inverse S-box result. Combinational, same cycle.
- `block` in 128: ciphertext. Must be held stable from `next` until the INIT cycle completes.
- `newBlock` out 128: working state / plaintext. Valid only while `ready`=1 after a completed operation.
- `ready` out 1: idle and result valid.

## Operation
- Working state is four 32-bit registers w0..w3 (w0 = bits 127:96). `newBlock` = {w0,w1,w2,w3}.
- 2-bit word counter `wctr`. 4-bit round counter `rctr`, which drives `round`.
- FSM states: IDLE, INIT, SHIFT, SBOX, MAIN.
- IDLE: if `next`=1, then `rctr`<=NUM_ROUNDS, `ready`<=0, go to INIT. Otherwise hold.
- INIT: state <= `block` ^ `roundKey` (key NUM_ROUNDS). `rctr`<=`rctr`-1. Go to SHIFT.
- SHIFT: state <= invShiftRows(state). Rotation is right: word j byte row r takes the byte from word (j-r) mod 4. `wctr`<=0. Go to SBOX.
- SBOX: `invSBoxRequest` = w[`wctr`]; w[`wctr`] <= `invSBoxResponse`; `wctr`++. When `wctr`=3, go to MAIN.
- MAIN, `rctr`>0: state <= invMixColumns(state ^ `roundKey`). `rctr`<=`rctr`-1. Go to SHIFT.
  - invMixColumns uses the {0e,0b,0d,09} circulant, with GF(2^8) reduction polynomial 0x11b.
- MAIN, `rctr`=0: state <= state ^ `roundKey` (key 0). `rctr` holds 0. `ready`<=1. Go to IDLE.
- `invSBoxRequest` = 0 in every state except SBOX.
- `next` while `ready`=0 is ignored; there is no queueing and no abort.
- `next` held high continuously: a new operation starts on the first IDLE cycle after completion, and re-samples `block`.
- `round` is 4 bits, counting down only. It never wraps below 0.

## Timing
- Reset values: `ready`=1, `newBlock`=0, `round`=0, `invSBoxRequest`=0. FSM=IDLE, `wctr`=0.
- Reset asserted mid-operation aborts immediately to these values. After reset releases, the block accepts `next` on the next edge.
- `next` sampled high at edge E0 (IDLE): `ready` low after E0. INIT executes at E0+1.
- Each round takes 6 edges: SHIFT 1, SBOX 4, MAIN 1.
- `ready`=1 and plaintext valid after edge E0+1+6·NUM_ROUNDS, i.e. E0+61 for AES-128.
- `round` values seen by the key store:
  - INIT: NUM_ROUNDS.
  - MAIN of decryption round r: r, with r running NUM_ROUNDS-1 down to 0.
- Intermediate `newBlock` values are visible while busy but carry no meaning.

## Configuration
- `AES_DEC_MERGED_SHIFT_EN` defined: the SHIFT state is removed.
  - INIT writes invShiftRows(`block` ^ `roundKey`).
  - MAIN with `rctr`>0 writes invShiftRows(invMixColumns(state ^ `roundKey`)) and clears `wctr`.
  - Latency is 1+5·NUM_ROUNDS edges (51 for AES-128). All other behaviour is identical.
- Undefined: the 6-cycle round described above, with a shorter critical path.

## Structure
- Shared package `aes_pkg`:
  - FSM state encodings.
  - AES_128_ROUNDS=10.
  - GF helpers mul2, mul9, mul11, mul13, mul14.
  - Functions invShiftRows and invMixWord.
- One natural sub-module: `aes_inv_mixcolumns`, a combinational 128-to-128 block built from four invMixWord instances.
- The inverse S-box stays external so it can be shared with the key path.

## Test plan
- Reset values: assert reset, then release -> `ready`=1, `newBlock`=0, `round`=0, `invSBoxRequest`=0.
- FIPS-197 App. B:
  - Stimulus: key 2b7e151628aed2a6abf7158809cf4f3c, ciphertext 3925841d02dc09fbdc118597196a0b32, pulse `next`.
  - Required: `newBlock`=3243f6a8885a308d313198a2e0370734, with `ready` rising exactly 61 cycles after `next`.
- FIPS-197 C.1:
  - Stimulus: key 000102…0f, ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a.
  - Required: 00112233445566778899aabbccddeeff.
  - Also check `round` sequence 10,9,…,0 at the key-use cycles.
- Pulse `next` at cycle 20 of a busy operation -> ignored; result and latency unchanged.
- Assert reset at cycle 30 of an operation, then issue a fresh `next` -> correct plaintext with full latency; no residue from the aborted run.
- Back-to-back runs:
  - Hold `next`=1 across two runs with different ciphertexts, one per run, changing `block` while `ready`=1.
  - Required: two correct results, with `ready` high for exactly one cycle between them.
  - Repeat the App. B vector with `AES_DEC_MERGED_SHIFT_EN` -> same result, latency 51.
